// File: rtl/io_port_regs_if.sv
// Command/response bus between the IO-port command generator (master) and the
// register slave: valid/ready command stream with write data and read return.
interface io_port_regs_if;
  logic [31:0] mem_data_wr1;
  logic [27:0] mem_data_addr1;
  logic        mem_rw_data1;
  logic        mem_valid_data1;
  logic [31:0] mem_data_rd1;
  logic        mem_ready_data1;

  modport master (
    output mem_data_wr1, mem_data_addr1, mem_rw_data1, mem_valid_data1,
    input  mem_data_rd1, mem_ready_data1
  );

  modport slave (
    input  mem_data_wr1, mem_data_addr1, mem_rw_data1, mem_valid_data1,
    output mem_data_rd1, mem_ready_data1
  );
endinterface

// File: rtl/io_port_regs.sv
// IO-port register slave: display start address, control, status and, when
// IO_PORT_ACCESS_CNT_EN is defined, a read-only count of mapped accesses.
module io_port_regs #(
  parameter logic [27:0] BASE_ADDR      = 28'h800_0004,
  parameter int unsigned ACCESS_LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  io_port_regs_if.slave      bus,
  output logic [31:0]        disp_start_addr,
  output logic               disp_on,
  output logic               disp_start,
  output logic               bus_err
);

  localparam logic [3:0] LAT = ACCESS_LATENCY[3:0];

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  lat_q, lat_d;
  logic [27:0] cmd_addr_q, cmd_addr_d;
  logic [31:0] cmd_wdata_q, cmd_wdata_d;
  logic        cmd_rw_q, cmd_rw_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [31:0] addr_reg_q, addr_reg_d;
  logic        on_q, on_d;
  logic        start_q, start_d;
  logic        err_q, err_d;
`ifdef IO_PORT_ACCESS_CNT_EN
  logic [15:0] cnt_q, cnt_d;
`endif

  logic [27:0] rd_off, wr_off;

  // Offsets wrap: an address below BASE_ADDR lands far outside the window.
  assign rd_off = cmd_addr_d - BASE_ADDR;
  assign wr_off = cmd_addr_q - BASE_ADDR;

  function automatic logic is_mapped(input logic [27:0] off);
`ifdef IO_PORT_ACCESS_CNT_EN
    return off < 28'd4;
`else
    return off < 28'd3;
`endif
  endfunction

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_rw_d    = cmd_rw_q;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_valid_data1) begin
          cmd_addr_d  = bus.mem_data_addr1;
          cmd_wdata_d = bus.mem_data_wr1;
          cmd_rw_d    = bus.mem_rw_data1;
          lat_d       = LAT;
          state_d     = (LAT == 4'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        lat_d = lat_q - 4'd1;
        if (lat_q <= 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_reg_d = addr_reg_q;
    on_d       = on_q;
    start_d    = 1'b0;
    err_d      = err_q;
    rd_data_d  = rd_data_q;
`ifdef IO_PORT_ACCESS_CNT_EN
    cnt_d      = cnt_q;
`endif
    if (state_q == RESP) begin
      if (!is_mapped(wr_off)) begin
        err_d = 1'b1;
      end else begin
`ifdef IO_PORT_ACCESS_CNT_EN
        cnt_d = cnt_q + 16'd1;
`endif
        if (cmd_rw_q) begin
          case (wr_off)
            28'd0: addr_reg_d = cmd_wdata_q;
            28'd1: begin
              on_d    = cmd_wdata_q[0];
              start_d = cmd_wdata_q[0] & ~on_q;
            end
            default: ;
          endcase
        end
      end
    end
    // Read data is captured on the way into RESP so it is already valid there
    // and holds until the next read response.
    if (state_d == RESP && state_q != RESP && !cmd_rw_d) begin
      case (rd_off)
        28'd0:   rd_data_d = addr_reg_q;
        28'd1:   rd_data_d = {31'b0, on_q};
        28'd2:   rd_data_d = {30'b0, err_q, on_q};
`ifdef IO_PORT_ACCESS_CNT_EN
        28'd3:   rd_data_d = {16'b0, cnt_q};
`endif
        default: rd_data_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lat_q       <= 4'd0;
      cmd_addr_q  <= 28'd0;
      cmd_wdata_q <= 32'd0;
      cmd_rw_q    <= 1'b0;
      rd_data_q   <= 32'd0;
      addr_reg_q  <= 32'd0;
      on_q        <= 1'b0;
      start_q     <= 1'b0;
      err_q       <= 1'b0;
`ifdef IO_PORT_ACCESS_CNT_EN
      cnt_q       <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_rw_q    <= cmd_rw_d;
      rd_data_q   <= rd_data_d;
      addr_reg_q  <= addr_reg_d;
      on_q        <= on_d;
      start_q     <= start_d;
      err_q       <= err_d;
`ifdef IO_PORT_ACCESS_CNT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.mem_ready_data1 = (state_q == RESP);
  assign bus.mem_data_rd1    = rd_data_q;
  assign disp_start_addr     = addr_reg_q;
  assign disp_on             = on_q;
  assign disp_start          = start_q;
  assign bus_err             = err_q;

endmodule

// File: tb/tb_io_port_regs.sv
// Bench for io_port_regs: directed plan plus random accesses against a register
// map model; a second instance with zero latency covers streaming commands.
module tb_io_port_regs;
  localparam logic [27:0] BASE = 28'h800_0004;
`ifdef IO_PORT_ACCESS_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  io_port_regs_if bus0 ();
  io_port_regs_if bus1 ();
  logic [31:0] dsa0, dsa1;
  logic        on0, on1, st0, st1, err0, err1;

  io_port_regs u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave),
    .disp_start_addr(dsa0), .disp_on(on0), .disp_start(st0), .bus_err(err0)
  );

  io_port_regs #(.ACCESS_LATENCY(0)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave),
    .disp_start_addr(dsa1), .disp_on(on1), .disp_start(st1), .bus_err(err1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_addr;
  logic        m_on, m_err;
  logic [15:0] m_cnt;
  logic [31:0] m_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_mapped(input logic [27:0] a);
    logic [27:0] off;
    off = a - BASE;
    return CNT_EN ? (off < 28'd4) : (off < 28'd3);
  endfunction

  function automatic logic [31:0] m_read(input logic [27:0] a);
    logic [27:0] off;
    off = a - BASE;
    if (!m_mapped(a)) return 32'h0;
    case (off)
      28'd0:   return m_addr;
      28'd1:   return {31'b0, m_on};
      28'd2:   return {30'b0, m_err, m_on};
      default: return {16'b0, m_cnt};
    endcase
  endfunction

  task automatic model_reset();
    m_addr = '0; m_on = 1'b0; m_err = 1'b0; m_cnt = '0; m_rd = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0;
    model_reset();
  endtask

  // One command on DUT0; entered and left on a falling edge.
  task automatic acc0(input logic rw, input logic [27:0] a, input logic [31:0] wd);
    int   k;
    logic exp_start;
    bus0.mem_rw_data1 = rw; bus0.mem_data_addr1 = a; bus0.mem_data_wr1 = wd;
    bus0.mem_valid_data1 = 1'b1;
    @(posedge clk); @(negedge clk);
    bus0.mem_valid_data1 = 1'b0;
    bus0.mem_data_addr1 = $urandom; bus0.mem_data_wr1 = $urandom;
    k = 1;
    while (!bus0.mem_ready_data1 && k < 16) begin
      @(negedge clk); k++;
    end
    chk("latency", k, 32'd3);
    if (!rw) m_rd = m_read(a);
    chk("rd_data", bus0.mem_data_rd1, m_rd);
    exp_start = 1'b0;
    if (!m_mapped(a)) m_err = 1'b1;
    else begin
      m_cnt = m_cnt + 16'd1;
      if (rw && a - BASE == 28'd0) m_addr = wd;
      if (rw && a - BASE == 28'd1) begin
        exp_start = wd[0] && !m_on;
        m_on = wd[0];
      end
    end
    @(negedge clk);
    chk("ready_pulse", bus0.mem_ready_data1, 1'b0);
    chk("disp_start", st0, exp_start);
    chk("disp_start_addr", dsa0, m_addr);
    chk("disp_on", on0, m_on);
    chk("bus_err", err0, m_err);
  endtask

  initial begin
    logic [31:0] b2b_val [0:15];
    logic [31:0] last_wr;
    bit          saw_ready;
    int          idx, cyc;

    bus0.mem_valid_data1 = 1'b0; bus0.mem_rw_data1 = 1'b0;
    bus0.mem_data_addr1 = '0;    bus0.mem_data_wr1 = '0;
    bus1.mem_valid_data1 = 1'b0; bus1.mem_rw_data1 = 1'b0;
    bus1.mem_data_addr1 = '0;    bus1.mem_data_wr1 = '0;
    model_reset();
    do_reset();

    chk("rst_ready", bus0.mem_ready_data1, 1'b0);
    chk("rst_rd", bus0.mem_data_rd1, 32'h0);
    chk("rst_addr", dsa0, 32'h0);
    chk("rst_on", on0, 1'b0);
    chk("rst_start", st0, 1'b0);
    chk("rst_err", err0, 1'b0);

    // Address register write then read back.
    acc0(1'b1, BASE, 32'h0100_0000);
    acc0(1'b0, BASE, 32'h0);
    chk("addr_readback", m_rd, 32'h0100_0000);

    // disp_start only on a 0->1 transition of disp_on.
    acc0(1'b1, BASE + 28'd1, 32'h1);
    acc0(1'b1, BASE + 28'd1, 32'h1);
    acc0(1'b1, BASE + 28'd1, 32'h0);
    acc0(1'b1, BASE + 28'd1, 32'hFFFF_FFFF);
    acc0(1'b0, BASE + 28'd1, 32'h0);

    // Offset 3 write, status read, below-base access.
    acc0(1'b1, BASE + 28'd3, 32'hA5A5_A5A5);
    acc0(1'b1, BASE + 28'd2, 32'hFFFF_FFFF);
    acc0(1'b0, BASE + 28'd2, 32'h0);
    if (!CNT_EN) chk("status_val", bus0.mem_data_rd1, 32'h3);
    acc0(1'b0, BASE - 28'd1, 32'h0);
    acc0(1'b0, BASE + 28'd4, 32'h0);
    chk("err_sticky", err0, 1'b1);

    // Five mapped accesses then the counter offset.
    do_reset();
    acc0(1'b1, BASE, 32'h1234_5678);
    acc0(1'b0, BASE, 32'h0);
    acc0(1'b1, BASE + 28'd1, 32'h1);
    acc0(1'b0, BASE + 28'd2, 32'h0);
    acc0(1'b0, BASE + 28'd1, 32'h0);
    acc0(1'b0, BASE + 28'd3, 32'h0);
    chk("cnt_read", bus0.mem_data_rd1, CNT_EN ? 32'h5 : 32'h0);
    chk("cnt_err", err0, CNT_EN ? 1'b0 : 1'b1);

    // Reset while a write waits: no ready, no commit, back to idle.
    do_reset();
    bus0.mem_rw_data1 = 1'b1; bus0.mem_data_addr1 = BASE;
    bus0.mem_data_wr1 = 32'hDEAD_BEEF; bus0.mem_valid_data1 = 1'b1;
    @(posedge clk); @(negedge clk);
    bus0.mem_valid_data1 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    saw_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus0.mem_ready_data1) saw_ready = 1'b1;
      @(negedge clk);
    end
    model_reset();
    chk("abort_no_ready", {31'b0, saw_ready}, 32'h0);
    chk("abort_addr", dsa0, 32'h0);
    acc0(1'b0, BASE, 32'h0);

    // Zero-latency instance with valid held high: write/read pairs.
    for (int i = 0; i < 16; i++) b2b_val[i] = $urandom;
    idx = 0; cyc = 0; last_wr = '0;
    bus1.mem_rw_data1 = 1'b1; bus1.mem_data_addr1 = BASE;
    bus1.mem_data_wr1 = b2b_val[0]; bus1.mem_valid_data1 = 1'b1;
    while (idx < 16 && cyc < 80) begin
      @(negedge clk);
      chk("b2b_ready", bus1.mem_ready_data1, (cyc % 2 == 0) ? 1'b1 : 1'b0);
      if (bus1.mem_ready_data1) begin
        if (idx % 2 == 0) last_wr = b2b_val[idx];
        else chk("b2b_rd", bus1.mem_data_rd1, last_wr);
        idx++;
        if (idx < 16) begin
          bus1.mem_rw_data1 = (idx % 2 == 0);
          bus1.mem_data_wr1 = b2b_val[idx];
        end else bus1.mem_valid_data1 = 1'b0;
      end
      cyc++;
    end
    chk("b2b_count", idx, 32'd16);
    @(negedge clk); @(negedge clk);
    chk("b2b_idle", bus1.mem_ready_data1, 1'b0);
    chk("b2b_dsa", dsa1, b2b_val[14]);

    // Random traffic against the model.
    for (int n = 0; n < 60; n++) begin
      int          sel;
      logic [27:0] a;
      sel = $urandom_range(0, 7);
      if (sel <= 4)      a = BASE + 28'(sel);
      else if (sel == 5) a = BASE - 28'($urandom_range(1, 8));
      else               a = 28'($urandom);
      acc0(1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
